// File: rtl/iob_ram_dp_be_dma_if.sv
// RAM-side bus between the DMA engine and a dual-port byte-enable RAM.
// Port A carries the read-only source stream and port B the write-only
// destination stream.
//   master : DMA engine (drives enables, write enables, addresses, write data)
//   slave  : RAM (returns port A read data, one cycle after en_a)
interface iob_ram_dp_be_dma_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic                en_a;
  logic [DATA_W/8-1:0] we_a;
  logic [ADDR_W-1:0]   addr_a;
  logic [DATA_W-1:0]   dout_a;
  logic                en_b;
  logic [DATA_W/8-1:0] we_b;
  logic [ADDR_W-1:0]   addr_b;
  logic [DATA_W-1:0]   din_b;

  modport master (
    output en_a, we_a, addr_a,
    input  dout_a,
    output en_b, we_b, addr_b, din_b
  );

  modport slave (
    input  en_a, we_a, addr_a,
    output dout_a,
    input  en_b, we_b, addr_b, din_b
  );
endinterface

// File: rtl/iob_ram_dp_be_dma.sv
// Block copy / fill DMA engine driving both ports of a read-first,
// registered-output dual-port byte-enable RAM (1-cycle read latency).
// Port A reads the source stream, port B writes the destination stream
// with a per-transfer byte strobe. One word per cycle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i           one-cycle request, accepted only in idle
//   mode_i            0 = copy src->dst, 1 = fill dst with fill_data_i
//   src_addr_i        source start word address (copy)
//   dst_addr_i        destination start word address
//   len_i             transfer length in words (0 .. 2**ADDR_W)
//   fill_data_i       fill pattern (fill)
//   wstrb_i           byte mask applied to every write
//   abort_i           cancel the transfer in progress
//   busy_o            transfer in progress
//   done_o            one-cycle pulse on normal completion
//   count_o           words written so far; holds after completion or abort
//   csum_o            sum of written data (only with IOB_RAM_DP_BE_DMA_CSUM_EN)
//   ram               RAM bus, master side
//
// Optional feature: define IOB_RAM_DP_BE_DMA_CSUM_EN to add csum_o, the
// modulo-2**DATA_W sum of din_b over every performed write.
module iob_ram_dp_be_dma #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = ADDR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [ADDR_W-1:0]     src_addr_i,
  input  logic [ADDR_W-1:0]     dst_addr_i,
  input  logic [LEN_W-1:0]      len_i,
  input  logic [DATA_W-1:0]     fill_data_i,
  input  logic [DATA_W/8-1:0]   wstrb_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [LEN_W-1:0]      count_o,
`ifdef IOB_RAM_DP_BE_DMA_CSUM_EN
  output logic [DATA_W-1:0]     csum_o,
`endif
  iob_ram_dp_be_dma_if.master   ram
);

  localparam int unsigned StrbW = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   src_q;
  logic [ADDR_W-1:0]   dst_q;
  logic [LEN_W-1:0]    len_q;
  logic                mode_q;
  logic [DATA_W-1:0]   fill_q;
  logic [StrbW-1:0]    wstrb_q;
  logic [LEN_W-1:0]    rd_cnt_q;
  logic [ADDR_W-1:0]   wr_cnt_q;
  logic                busy_q;
  logic                done_q;
  logic [LEN_W-1:0]    count_q;
  logic                en_a_q;
  logic [ADDR_W-1:0]   addr_a_q;
  logic                en_b_q;
  logic [StrbW-1:0]    we_b_q;
  logic [ADDR_W-1:0]   addr_b_q;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   din_b;
`ifdef IOB_RAM_DP_BE_DMA_CSUM_EN
  logic [DATA_W-1:0]   csum_q;
`endif

  // Address arithmetic wraps modulo 2**ADDR_W.
  assign rd_addr = src_q + rd_cnt_q[ADDR_W-1:0];
  assign wr_addr = dst_q + wr_cnt_q;

  // The RAM output is registered, so read data lines up with the registered
  // write strobe one cycle after the issue. Gated to 0 between writes.
  assign din_b = en_b_q ? (mode_q ? fill_q : ram.dout_a) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      mode_q   <= 1'b0;
      fill_q   <= '0;
      wstrb_q  <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
      en_a_q   <= 1'b0;
      addr_a_q <= '0;
      en_b_q   <= 1'b0;
      we_b_q   <= '0;
      addr_b_q <= '0;
`ifdef IOB_RAM_DP_BE_DMA_CSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      // A write is performed in every cycle en_b_q is high, including the
      // cycle in which abort is sampled.
      if (en_b_q) begin
        count_q <= count_q + LEN_W'(1);
`ifdef IOB_RAM_DP_BE_DMA_CSUM_EN
        csum_q  <= csum_q + din_b;
`endif
      end

      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            src_q    <= src_addr_i;
            dst_q    <= dst_addr_i;
            len_q    <= len_i;
            mode_q   <= mode_i;
            fill_q   <= fill_data_i;
            wstrb_q  <= wstrb_i;
            rd_cnt_q <= LEN_W'(1);
            wr_cnt_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b1;
`ifdef IOB_RAM_DP_BE_DMA_CSUM_EN
            csum_q   <= '0;
`endif
            if (len_i == '0) begin
              // Zero length passes through the drain cycle with no RAM
              // access so done latency stays len+2 for every length.
              state_q <= StDrain;
            end else begin
              state_q  <= StRun;
              en_a_q   <= ~mode_i;
              addr_a_q <= src_addr_i;
            end
          end
        end

        StRun: begin
          if (abort_i) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            en_a_q  <= 1'b0;
            en_b_q  <= 1'b0;
            we_b_q  <= '0;
          end else begin
            // Every run cycle is an issue; its write follows next cycle.
            en_b_q   <= 1'b1;
            we_b_q   <= wstrb_q;
            addr_b_q <= wr_addr;
            wr_cnt_q <= wr_cnt_q + ADDR_W'(1);
            if (rd_cnt_q == len_q) begin
              en_a_q  <= 1'b0;
              state_q <= StDrain;
            end else begin
              en_a_q   <= ~mode_q;
              addr_a_q <= rd_addr;
              rd_cnt_q <= rd_cnt_q + LEN_W'(1);
            end
          end
        end

        StDrain: begin
          en_b_q  <= 1'b0;
          we_b_q  <= '0;
          busy_q  <= 1'b0;
          if (abort_i) begin
            state_q <= StIdle;
          end else begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign count_o    = count_q;
`ifdef IOB_RAM_DP_BE_DMA_CSUM_EN
  assign csum_o     = csum_q;
`endif
  assign ram.en_a   = en_a_q;
  assign ram.we_a   = '0;
  assign ram.addr_a = addr_a_q;
  assign ram.en_b   = en_b_q;
  assign ram.we_b   = we_b_q;
  assign ram.addr_b = addr_b_q;
  assign ram.din_b  = din_b;

endmodule

// File: tb/tb_iob_ram_dp_be_dma.sv
// Directed bench for iob_ram_dp_be_dma with a behavioural read-first
// dual-port byte-enable RAM. Inputs change 1 ns after posedge; outputs are
// sampled on negedge.
module tb_iob_ram_dp_be_dma;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = ADDR_W + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              mode = 1'b0;
  logic [ADDR_W-1:0] src_addr = '0;
  logic [ADDR_W-1:0] dst_addr = '0;
  logic [LEN_W-1:0]  len = '0;
  logic [DATA_W-1:0] fill_data = '0;
  logic [3:0]        wstrb = '0;
  logic              abort = 1'b0;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  count;
`ifdef IOB_RAM_DP_BE_DMA_CSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  int checks = 0;
  int errors = 0;

  // RAM model, loaded through a side port so mem has a single writer.
  logic [DATA_W-1:0] mem [1024];
  logic              clr = 1'b0;
  logic              ld_en = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [DATA_W-1:0] ld_data = '0;

  // Activity monitor, sampled on negedge.
  int n_en_a = 0;
  int n_en_b = 0;
  int n_we_a = 0;
  int n_done = 0;

  iob_ram_dp_be_dma_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ram_if ();

  iob_ram_dp_be_dma #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .mode_i      (mode),
    .src_addr_i  (src_addr),
    .dst_addr_i  (dst_addr),
    .len_i       (len),
    .fill_data_i (fill_data),
    .wstrb_i     (wstrb),
    .abort_i     (abort),
    .busy_o      (busy),
    .done_o      (done),
    .count_o     (count),
`ifdef IOB_RAM_DP_BE_DMA_CSUM_EN
    .csum_o      (csum),
`endif
    .ram         (ram_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else begin
      if (ld_en) mem[ld_addr] <= ld_data;
      if (ram_if.en_a) ram_if.dout_a <= mem[ram_if.addr_a];
      if (ram_if.en_b) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_if.we_b[b]) mem[ram_if.addr_b][8*b +: 8] <= ram_if.din_b[8*b +: 8];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_if.en_a) n_en_a++;
      if (ram_if.en_b) n_en_b++;
      if (ram_if.we_a != '0) n_we_a++;
      if (done) n_done++;
    end
  end

  task automatic load_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Pulses start for one edge, then scrambles the inputs so a design that
  // fails to latch them misbehaves. Returns 1 ns into cycle T+1.
  task automatic start_xfer(input logic m, input logic [ADDR_W-1:0] s,
                            input logic [ADDR_W-1:0] d, input logic [LEN_W-1:0] l,
                            input logic [DATA_W-1:0] f, input logic [3:0] w);
    mode = m; src_addr = s; dst_addr = d; len = l; fill_data = f; wstrb = w;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mode = ~m; src_addr = ~s; dst_addr = ~d; len = 11'd5; fill_data = ~f; wstrb = ~w;
  endtask

  // Returns the cycle index n (done seen in cycle T+n), or 0 on timeout.
  task automatic wait_done(input int first, output int cyc);
    cyc = 0;
    for (int n = first; n <= 200; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({busy, done, count} !== '0) begin
      errors++; $display("FAIL reset_ctrl busy=%b done=%b count=%0d want 0", busy, done, count);
    end
    checks++;
    if ({ram_if.en_a, ram_if.en_b, ram_if.we_a, ram_if.we_b} !== '0) begin
      errors++; $display("FAIL reset_en en_a=%b en_b=%b we_a=%h we_b=%h want 0",
                         ram_if.en_a, ram_if.en_b, ram_if.we_a, ram_if.we_b);
    end
    checks++;
    if ({ram_if.addr_a, ram_if.addr_b, ram_if.din_b} !== '0) begin
      errors++; $display("FAIL reset_bus addr_a=%h addr_b=%h din_b=%h want 0",
                         ram_if.addr_a, ram_if.addr_b, ram_if.din_b);
    end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_copy;
    int cyc, ea, eb, wa;
    load_word(10'd0, 32'd11); load_word(10'd1, 32'd22);
    load_word(10'd2, 32'd33); load_word(10'd3, 32'd44);
    ea = n_en_a; eb = n_en_b; wa = n_we_a;
    start_xfer(1'b0, 10'd0, 10'd100, 11'd4, 32'h0, 4'hF);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || ram_if.en_a !== 1'b1 || ram_if.addr_a !== 10'd0) begin
      errors++; $display("FAIL copy_first_issue busy=%b en_a=%b addr_a=%0d want 1 1 0",
                         busy, ram_if.en_a, ram_if.addr_a);
    end
    wait_done(2, cyc);
    checks++;
    if (cyc != 6) begin errors++; $display("FAIL copy_done_latency got %0d want 6", cyc); end
    checks++;
    if (count !== 11'd4 || busy !== 1'b0) begin
      errors++; $display("FAIL copy_count count=%0d busy=%b want 4 0", count, busy);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[100+i] !== 32'(11 * (i + 1))) begin
        errors++; $display("FAIL copy_data[%0d] got %0d want %0d", i, mem[100+i], 11 * (i + 1));
      end
    end
    checks++;
    if (n_en_a - ea != 4 || n_en_b - eb != 4 || n_we_a - wa != 0) begin
      errors++; $display("FAIL copy_activity en_a=%0d en_b=%0d we_a=%0d want 4 4 0",
                         n_en_a - ea, n_en_b - eb, n_we_a - wa);
    end
  endtask

  task automatic test_fill;
    int cyc, ea;
    load_word(10'd10, 32'h0); load_word(10'd11, 32'h0); load_word(10'd12, 32'h0);
    ea = n_en_a;
    start_xfer(1'b1, 10'd0, 10'd10, 11'd3, 32'hAABBCCDD, 4'b0101);
    wait_done(1, cyc);
    checks++;
    if (cyc != 5) begin errors++; $display("FAIL fill_done_latency got %0d want 5", cyc); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[10+i] !== 32'h00BB00DD) begin
        errors++; $display("FAIL fill_data[%0d] got %h want 00bb00dd", i, mem[10+i]);
      end
    end
    checks++;
    if (n_en_a != ea || count !== 11'd3) begin
      errors++; $display("FAIL fill_no_read en_a=%0d count=%0d want 0 3", n_en_a - ea, count);
    end
  endtask

  task automatic test_wrap_len0;
    int cyc, ea, eb;
    load_word(10'd1022, 32'hA1); load_word(10'd1023, 32'hA2); load_word(10'd0, 32'hA3);
    start_xfer(1'b0, 10'd1022, 10'd5, 11'd3, 32'h0, 4'hF);
    wait_done(1, cyc);
    checks++;
    if (mem[5] !== 32'hA1 || mem[6] !== 32'hA2 || mem[7] !== 32'hA3) begin
      errors++; $display("FAIL wrap_data got %h %h %h want a1 a2 a3", mem[5], mem[6], mem[7]);
    end
    @(posedge clk); #1;
    ea = n_en_a; eb = n_en_b;
    start_xfer(1'b0, 10'd50, 10'd60, 11'd0, 32'h0, 4'hF);
    wait_done(1, cyc);
    checks++;
    if (cyc != 2) begin errors++; $display("FAIL len0_done_latency got %0d want 2", cyc); end
    checks++;
    if (n_en_a != ea || n_en_b != eb || count !== 11'd0) begin
      errors++; $display("FAIL len0_no_access en_a=%0d en_b=%0d count=%0d want 0 0 0",
                         n_en_a - ea, n_en_b - eb, count);
    end
  endtask

  task automatic test_abort;
    int dn;
    for (int i = 0; i < 8; i++) begin
      load_word(10'(200 + i), 32'h100 + 32'(i));
      load_word(10'(300 + i), 32'hDEAD0000 + 32'(i));
    end
    dn = n_done;
    start_xfer(1'b0, 10'd200, 10'd300, 11'd8, 32'h0, 4'hF);
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ram_if.en_b !== 1'b0 || ram_if.en_a !== 1'b0) begin
      errors++; $display("FAIL abort_stop busy=%b en_a=%b en_b=%b want 0 0 0",
                         busy, ram_if.en_a, ram_if.en_b);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (count !== 11'd3 || n_done != dn) begin
      errors++; $display("FAIL abort_count count=%0d dones=%0d want 3 0", count, n_done - dn);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[300+i] !== (i < 3 ? 32'h100 + 32'(i) : 32'hDEAD0000 + 32'(i))) begin
        errors++; $display("FAIL abort_data[%0d] got %h", i, mem[300+i]);
      end
    end
  endtask

  task automatic test_busy_start;
    int cyc, eb, dn;
    @(posedge clk); #1;
    eb = n_en_b; dn = n_done;
    start_xfer(1'b0, 10'd0, 10'd400, 11'd4, 32'h0, 4'hF);
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b0; src_addr = 10'd0; dst_addr = 10'd500; len = 11'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(3, cyc);
    checks++;
    if (cyc != 6) begin errors++; $display("FAIL busy_start_latency got %0d want 6", cyc); end
    // Start held through the done cycle must also be ignored.
    start = 1'b1; len = 11'd2;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL done_cycle_start busy=%b want 0", busy); end
    repeat (4) @(negedge clk);
    checks++;
    if (n_en_b - eb != 4 || n_done - dn != 1 || count !== 11'd4) begin
      errors++; $display("FAIL busy_start_ignored writes=%0d dones=%0d count=%0d want 4 1 4",
                         n_en_b - eb, n_done - dn, count);
    end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    start_xfer(1'b0, 10'd0, 10'd800, 11'd8, 32'h0, 4'hF);
    @(posedge clk); @(posedge clk); #2;
    checks++;
    if (busy !== 1'b1 || ram_if.en_b !== 1'b1) begin
      errors++; $display("FAIL reset_mid_pre busy=%b en_b=%b want 1 1", busy, ram_if.en_b);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || ram_if.en_b !== 1'b0 || count !== 11'd0 || ram_if.en_a !== 1'b0) begin
      errors++; $display("FAIL reset_mid busy=%b en_a=%b en_b=%b count=%0d want 0 0 0 0",
                         busy, ram_if.en_a, ram_if.en_b, count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ram_if.en_b !== 1'b0) begin
      errors++; $display("FAIL reset_mid_idle busy=%b en_b=%b want 0 0", busy, ram_if.en_b);
    end
    @(posedge clk); #1;
  endtask

`ifdef IOB_RAM_DP_BE_DMA_CSUM_EN
  task automatic test_csum;
    int cyc;
    load_word(10'd600, 32'd1); load_word(10'd601, 32'd2);
    load_word(10'd602, 32'd3); load_word(10'd603, 32'hFFFFFFFF);
    start_xfer(1'b0, 10'd600, 10'd700, 11'd4, 32'h0, 4'h1);
    wait_done(1, cyc);
    checks++;
    if (csum !== 32'd5) begin errors++; $display("FAIL csum_sum got %h want 5", csum); end
    @(posedge clk); #1;
    start_xfer(1'b0, 10'd600, 10'd710, 11'd2, 32'h0, 4'hF);
    @(negedge clk);
    checks++;
    if (csum !== 32'd0) begin errors++; $display("FAIL csum_clear got %h want 0", csum); end
    wait_done(2, cyc);
    checks++;
    if (csum !== 32'd3) begin errors++; $display("FAIL csum_second got %h want 3", csum); end
  endtask
`endif

  initial begin
    test_reset();
    test_copy();
    test_fill();
    test_wrap_len0();
    test_abort();
    test_busy_start();
    test_reset_mid();
`ifdef IOB_RAM_DP_BE_DMA_CSUM_EN
    test_csum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
